fifo_status: RTL and testbench

FIFO_STATUS -- requirements
Module: fifo_status

---
 rtl/fifo_status_if.sv | 30 +++
 rtl/fifo_status.sv | 59 +++++
 tb/tb_fifo_status.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fifo_status_if.sv
// Status bus between the FIFO pointer stages and the occupancy/flag tracker.
// The pointer side owns the pointers and requests; the tracker drives all flags.
interface fifo_status_if #(
    parameter int PTR_W = 5
);
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr;
    logic             rd;
    logic             clr_flags;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_threshold;
    logic [PTR_W-1:0] fifo_level;
    logic [PTR_W-1:0] fifo_hwm;
    logic             fifo_overflow;
    logic             fifo_underflow;

    modport master (
        output wptr, rptr, wr, rd, clr_flags,
        input  fifo_full, fifo_empty, fifo_threshold, fifo_level,
               fifo_hwm, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  wptr, rptr, wr, rd, clr_flags,
        output fifo_full, fifo_empty, fifo_threshold, fifo_level,
               fifo_hwm, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_status.sv
// FIFO status tracker: zero-latency full/empty from wrap-bit pointers, plus
// registered occupancy, almost-full, high-water mark and sticky error flags.
module fifo_status #(
    parameter int PTR_W  = 5,
    parameter int THRESH = 12
) (
    input  logic          clk,
    input  logic          rst,
    fifo_status_if.slave  bus
);
    localparam logic [PTR_W-1:0] THRESH_V = PTR_W'(THRESH);

    logic [PTR_W-1:0] diff;
    logic             full_c;
    logic             empty_c;
    logic             threshold_q;
    logic [PTR_W-1:0] level_q;
    logic [PTR_W-1:0] hwm_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             overflow_set;
    logic             underflow_set;

    // Modular subtraction handles the wrap: the MSB disambiguates full from empty.
    assign diff    = bus.wptr - bus.rptr;
    assign empty_c = (bus.wptr == bus.rptr);
    assign full_c  = (bus.wptr[PTR_W-1] != bus.rptr[PTR_W-1]) &&
                     (bus.wptr[PTR_W-2:0] == bus.rptr[PTR_W-2:0]);

    assign overflow_set  = bus.wr & full_c;
    assign underflow_set = bus.rd & empty_c;

    // A set event in the same cycle as clr_flags must leave the flag asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            threshold_q <= 1'b0;
            hwm_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= diff;
            threshold_q <= (diff >= THRESH_V);
            overflow_q  <= overflow_set  | (overflow_q  & ~bus.clr_flags);
            underflow_q <= underflow_set | (underflow_q & ~bus.clr_flags);
            if (bus.clr_flags || (diff > hwm_q)) begin
                hwm_q <= diff;
            end
        end
    end

    assign bus.fifo_full      = full_c;
    assign bus.fifo_empty     = empty_c;
    assign bus.fifo_threshold = threshold_q;
    assign bus.fifo_level     = level_q;
    assign bus.fifo_hwm       = hwm_q;
    assign bus.fifo_overflow  = overflow_q;
    assign bus.fifo_underflow = underflow_q;
endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: directed scenarios followed by random
// pointer/request traffic, all checked against an occupancy-based reference model.
module tb_fifo_status;
    localparam int PTR_W  = 5;
    localparam int THRESH = 12;
    localparam int DEPTH  = 16;
    localparam int MODULO = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference state, advanced once per rising edge from the spec's rules.
    int   mLevel;
    int   mHwm;
    bit   mThresh;
    bit   mOvf;
    bit   mUnd;

    fifo_status_if #(.PTR_W(PTR_W)) bus ();

    fifo_status #(.PTR_W(PTR_W), .THRESH(THRESH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int occupancy(input int w, input int r);
        return (w + MODULO - r) % MODULO;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".level"},     32'(bus.fifo_level),     32'(mLevel));
        checkOutput({tag, ".threshold"}, 32'(bus.fifo_threshold), 32'(mThresh));
        checkOutput({tag, ".hwm"},       32'(bus.fifo_hwm),       32'(mHwm));
        checkOutput({tag, ".overflow"},  32'(bus.fifo_overflow),  32'(mOvf));
        checkOutput({tag, ".underflow"}, 32'(bus.fifo_underflow), 32'(mUnd));
    endtask

    task automatic modelReset();
        mLevel  = 0;
        mHwm    = 0;
        mThresh = 1'b0;
        mOvf    = 1'b0;
        mUnd    = 1'b0;
    endtask

    // Drives one cycle of inputs, checks the combinational flags mid-cycle,
    // then checks the registered outputs just after the following edge.
    task automatic applyStimulus(input string tag, input int w, input int r,
                                 input bit wrv, input bit rdv, input bit clr);
        int  occ;
        bit  isFull;
        bit  isEmpty;
        bus.wptr      = PTR_W'(w);
        bus.rptr      = PTR_W'(r);
        bus.wr        = wrv;
        bus.rd        = rdv;
        bus.clr_flags = clr;
        occ     = occupancy(w, r);
        isFull  = (occ == DEPTH);
        isEmpty = (occ == 0);
        #1;
        checkOutput({tag, ".full"},  32'(bus.fifo_full),  32'(isFull));
        checkOutput({tag, ".empty"}, 32'(bus.fifo_empty), 32'(isEmpty));
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            mLevel  = occ;
            mThresh = (occ >= THRESH);
            mOvf    = (wrv && isFull)  ? 1'b1 : (clr ? 1'b0 : mOvf);
            mUnd    = (rdv && isEmpty) ? 1'b1 : (clr ? 1'b0 : mUnd);
            if (clr)             mHwm = occ;
            else if (occ > mHwm) mHwm = occ;
        end
        #1;
        checkRegs(tag);
    endtask

    initial begin
        int r;
        int occ;
        checks   = 0;
        failures = 0;
        modelReset();
        rst           = 1'b1;
        bus.wptr      = '0;
        bus.rptr      = '0;
        bus.wr        = 1'b0;
        bus.rd        = 1'b0;
        bus.clr_flags = 1'b0;

        // Reset state with pointers at zero.
        #2;
        checkOutput("reset.empty", 32'(bus.fifo_empty), 32'd1);
        checkOutput("reset.full",  32'(bus.fifo_full),  32'd0);
        checkRegs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("idle0", 0, 0, 1'b0, 1'b0, 1'b0);

        // Fill ramp: wptr 0..16 with rptr held at 0.
        for (int w = 0; w <= DEPTH; w++) begin
            applyStimulus($sformatf("ramp%0d", w), w, 0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("ramp.hwm16",  32'(bus.fifo_hwm),       32'd16);
        checkOutput("ramp.thresh", 32'(bus.fifo_threshold), 32'd1);

        // Overflow is sticky through idle cycles, then cleared.
        applyStimulus("ovf.set", 16, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("ovf.set.direct", 32'(bus.fifo_overflow), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("ovf.hold", 16, 0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("ovf.hold.direct", 32'(bus.fifo_overflow), 32'd1);
        applyStimulus("ovf.clr", 16, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf.clr.direct", 32'(bus.fifo_overflow), 32'd0);
        checkOutput("ovf.clr.hwm",    32'(bus.fifo_hwm),      32'd16);

        // Underflow set and clear in the same cycle: set wins.
        applyStimulus("und.setwins", 7, 7, 1'b0, 1'b1, 1'b1);
        checkOutput("und.setwins.direct", 32'(bus.fifo_underflow), 32'd1);
        checkOutput("und.clr.hwm",        32'(bus.fifo_hwm),       32'd0);

        // Simultaneous wr and rd at full and at empty.
        applyStimulus("both.full",  20, 4, 1'b1, 1'b1, 1'b1);
        applyStimulus("both.empty", 9,  9, 1'b1, 1'b1, 1'b1);

        // Pointer wrap.
        applyStimulus("wrap.a", 2, 30, 1'b0, 1'b0, 1'b0);
        applyStimulus("wrap.b", 2, 30, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap.level4", 32'(bus.fifo_level), 32'd4);
        applyStimulus("wrap.c", 2, 2, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap.level0", 32'(bus.fifo_level), 32'd0);

        // Asynchronous reset mid-operation with level 9 and overflow set.
        applyStimulus("pre.ovf", 16, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus("pre.lvl", 9, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre.level9", 32'(bus.fifo_level),    32'd9);
        checkOutput("pre.ovf1",   32'(bus.fifo_overflow), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkRegs("async");
        applyStimulus("inreset", 9, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus("postreset", 11, 1, 1'b0, 1'b0, 1'b0);

        // Random legal pointer pairs with random requests.
        for (int i = 0; i < 200; i++) begin
            r   = int'($urandom_range(0, MODULO - 1));
            occ = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : DEPTH)
                                               : int'($urandom_range(0, DEPTH));
            applyStimulus("rand", (r + occ) % MODULO, r,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0));
            checkOutput("rand.excl", 32'(bus.fifo_full & bus.fifo_empty), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
